// File: rtl/reu_dma_seq.sv
// -----------------------------------------------------------------------------
// reu_dma_seq
//
// Purpose:
//   DMA sequencer for the REU register block. On Execute it takes the C64 bus
//   (nDMA low), then moves one byte at a time between the C64 bus and SDRAM
//   according to the transfer type latched at start:
//     00 stash  : C64 -> REU
//     01 fetch  : REU -> C64
//     10 swap   : C64 <-> REU
//     11 verify : compare C64 and REU, stop on the first difference
//   After each byte it pulses the register block's step strobes. Address
//   generation and length counting live in the register block.
//
// Timing:
//   All state updates happen on the falling edge of PHI2. Outputs are Moore
//   outputs of the current state. The only exception is SetEndOfBlock, which
//   also looks at the Length1 input in STEP and CMP.
//
// Ports:
//   PHI2, nRESET        clock (falling-edge active), async active-low reset
//   Execute, XferType   start strobe and transfer type from the register block
//   Length1             remaining length == 1 (before this byte's decrement)
//   BA                  VIC bus available; 0 holds any C64 bus cycle
//   CDin/CDout/CDOE     C64 data bus in, out and output enable
//   CAOE, RnW, nDMA     C64 address enable, R/W (1 = read), DMA request
//   RAMReq/RAMWE/RAMWRD SDRAM request, write enable and write data
//   RAMRDD/RAMAck       SDRAM read data and one-cycle completion pulse
//   IncCA/IncREUA/DecLen step strobes (one-cycle pulses)
//   XferEnd, SetEndOfBlock, SetVerifyErr  end and status pulses
//   Busy                sequencer not idle
// -----------------------------------------------------------------------------
module reu_dma_seq #(
    parameter int START_DELAY = 1
) (
    input  logic       PHI2,
    input  logic       nRESET,
    input  logic       Execute,
    input  logic [1:0] XferType,
    input  logic       Length1,
    input  logic       BA,
    input  logic [7:0] CDin,
    output logic [7:0] CDout,
    output logic       CDOE,
    output logic       CAOE,
    output logic       RnW,
    output logic       nDMA,
    output logic       RAMReq,
    output logic       RAMWE,
    output logic [7:0] RAMWRD,
    input  logic [7:0] RAMRDD,
    input  logic       RAMAck,
    output logic       IncCA,
    output logic       IncREUA,
    output logic       DecLen,
    output logic       XferEnd,
    output logic       SetEndOfBlock,
    output logic       SetVerifyErr,
    output logic       Busy
);

    localparam logic [1:0] T_STASH  = 2'b00;
    localparam logic [1:0] T_FETCH  = 2'b01;
    localparam logic [1:0] T_SWAP   = 2'b10;
    localparam logic [1:0] T_VERIFY = 2'b11;

    // Last count value of the START hold; START lasts START_DELAY cycles.
    localparam logic [2:0] DELAY_LAST = 3'(START_DELAY - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_C64RD,
        S_RAMRD,
        S_RAMWR,
        S_C64WR,
        S_CMP,
        S_STEP,
        S_END
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] t_q, t_d;      // transfer type latched at Execute
    logic [2:0] cnt_q, cnt_d;  // START delay counter
    logic [7:0] c_q, c_d;      // byte read from the C64 bus
    logic [7:0] r_q, r_d;      // byte read from SDRAM

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            t_q     <= 2'b00;
            cnt_q   <= 3'd0;
            c_q     <= 8'h00;
            r_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        t_d           = t_q;
        cnt_d         = cnt_q;
        c_d           = c_q;
        r_d           = r_q;
        CDout         = 8'h00;
        CDOE          = 1'b0;
        CAOE          = 1'b0;
        RnW           = 1'b1;
        nDMA          = 1'b0;   // the bus is held in every state but IDLE
        RAMReq        = 1'b0;
        RAMWE         = 1'b0;
        RAMWRD        = 8'h00;
        IncCA         = 1'b0;
        IncREUA       = 1'b0;
        DecLen        = 1'b0;
        XferEnd       = 1'b0;
        SetEndOfBlock = 1'b0;
        SetVerifyErr  = 1'b0;
        Busy          = 1'b1;

        case (state_q)
            S_IDLE: begin
                nDMA  = 1'b1;
                Busy  = 1'b0;
                cnt_d = 3'd0;
                if (Execute) begin
                    t_d     = XferType;
                    state_d = S_START;
                end
            end

            // Gives the CPU time to let go of the bus after nDMA falls.
            S_START: begin
                if (cnt_q == DELAY_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = (t_q == T_FETCH) ? S_RAMRD : S_C64RD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_C64RD: begin
                CAOE = 1'b1;
                if (BA) begin
                    c_d     = CDin;
                    state_d = (t_q == T_STASH) ? S_RAMWR : S_RAMRD;
                end
            end

            S_RAMRD: begin
                RAMReq = 1'b1;
                if (RAMAck) begin
                    r_d = RAMRDD;
                    case (t_q)
                        T_FETCH:  state_d = S_C64WR;
                        T_SWAP:   state_d = S_RAMWR;
                        T_VERIFY: state_d = S_CMP;
                        default:  state_d = S_STEP;  // stash never reads SDRAM
                    endcase
                end
            end

            S_RAMWR: begin
                RAMReq = 1'b1;
                RAMWE  = 1'b1;
                RAMWRD = c_q;
                if (RAMAck) begin
                    state_d = (t_q == T_SWAP) ? S_C64WR : S_STEP;
                end
            end

            S_C64WR: begin
                CAOE  = 1'b1;
                CDOE  = 1'b1;
                RnW   = 1'b0;
                CDout = r_q;
                if (BA) begin
                    state_d = S_STEP;
                end
            end

            // A verify difference ends the block without stepping addresses,
            // so the register block keeps pointing at the failing byte.
            S_CMP: begin
                if (c_q == r_q) begin
                    state_d = S_STEP;
                end else begin
                    SetVerifyErr  = 1'b1;
                    SetEndOfBlock = Length1;
                    state_d       = S_END;
                end
            end

            // Length1 is still the pre-decrement value here.
            S_STEP: begin
                IncCA   = 1'b1;
                IncREUA = 1'b1;
                DecLen  = 1'b1;
                if (Length1) begin
                    SetEndOfBlock = 1'b1;
                    state_d       = S_END;
                end else begin
                    state_d = (t_q == T_FETCH) ? S_RAMRD : S_C64RD;
                end
            end

            S_END: begin
                XferEnd = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/reu_dma_seq.md
Name: reu_dma_seq

Overview:
DMA sequencer for the REU register block. It starts on Execute and takes the C64 bus via nDMA. For each byte it runs C64 bus cycles and SDRAM accesses according to XferType: 00 stash, 01 fetch, 10 swap, 11 verify. It then pulses the register block's step/status strobes (IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr). Address values come from the register block; this block only sequences and moves data.

Parameters:
START_DELAY, 1, PHI2 cycles after nDMA assertion before the first bus cycle may begin (CPU release margin); range 1-7.

Ports:
PHI2  input  1  system clock; all state updates on falling edge
nRESET  input  1  asynchronous active-low reset
Execute  input  1  start strobe from register block
XferType  input  2  transfer type (bypassed value from register block)
Length1  input  1  remaining length == 1
BA  input  1  VIC bus available; 0 = bus stolen, hold
CDin  input  8  C64 data bus in
CDout  output  8  C64 data bus out
CDOE  output  1  drive CDout onto C64 data bus
CAOE  output  1  drive C64 address (CA) onto bus
RnW  output  1  C64 R/W (1 = read)
nDMA  output  1  C64 DMA request, active low
RAMReq  output  1  SDRAM access request
RAMWE  output  1  SDRAM write (valid with RAMReq)
RAMWRD  output  8  SDRAM write data
RAMRDD  input  8  SDRAM read data, valid with RAMAck
RAMAck  input  1  SDRAM access complete, one-cycle pulse
IncCA, IncREUA, DecLen  output  1 each  step strobes, one-cycle pulses
XferEnd  output  1  transfer end pulse
SetEndOfBlock, SetVerifyErr  output  1 each  status set pulses
Busy  output  1  state != IDLE

Behaviour:
- Reset (nRESET=0, async, any state): state=IDLE; nDMA=1; RnW=1; all other outputs 0; delay counter 0; data latches C,R = 0. A reset mid-transfer releases the bus immediately with no XferEnd.
- States: IDLE, START, C64RD, RAMRD, RAMWR, C64WR, CMP, STEP, END.
- IDLE: Execute=1 -> START; latch XferType into internal T. Execute is ignored in every other state.
- START: nDMA=0 (held 0 in all states except IDLE). Counter counts START_DELAY cycles, then branch: T=01 -> RAMRD; otherwise -> C64RD.
- C64RD: CAOE=1, RnW=1. At the edge with BA=1: latch C<=CDin, advance. BA=0: hold with outputs unchanged.
  - Next: T=00 -> RAMWR; T=10 or 11 -> RAMRD.
- RAMRD: RAMReq=1, RAMWE=0 until RAMAck; on RAMAck latch R<=RAMRDD.
  - Next: T=01 -> C64WR; T=10 -> RAMWR; T=11 -> CMP.
- RAMWR: RAMReq=1, RAMWE=1, RAMWRD=C until RAMAck.
  - Next: T=00 -> STEP; T=10 -> C64WR.
- C64WR: CAOE=1, CDOE=1, RnW=0, CDout=R. Completes at the edge with BA=1 -> STEP. BA=0 holds.
- CMP (one cycle):
  - C==R -> STEP.
  - C!=R -> END, with SetVerifyErr=1 this cycle. SetEndOfBlock=1 too if Length1=1. No step strobes.
- STEP (one cycle): IncCA=IncREUA=DecLen=1.
  - Length1=1 (sampled this cycle, before the decrement lands): SetEndOfBlock=1, -> END.
  - Otherwise the next byte starts: -> C64RD, or -> RAMRD when T=01. No START delay.
- END (one cycle): XferEnd=1, nDMA=0; then -> IDLE with nDMA=1.
- All strobes are single-cycle, Moore outputs of the current state. Per-byte IncMode gating is the register block's job; this block always pulses all three step strobes.
- Throughput with BA=1 and a single-cycle RAMAck (per byte): stash = 3 cycles (C64RD, RAMWR, STEP); swap = 5.
- RAMAck arriving in any state other than RAMRD/RAMWR is ignored.
- Length 0 (= 65536) needs no special handling; only Length1 ends a block.

Test Plan:
- Stash 2 bytes, BA=1, RAMAck 1 cycle after RAMReq, CDin=0x5A then 0xA5 -> RAMWRD 0x5A, 0xA5 with RAMWE=1; exactly 2 IncCA/IncREUA/DecLen pulses; SetEndOfBlock and XferEnd on the last byte; nDMA low from START to END inclusive.
- Fetch 1 byte, RAMRDD=0x3C -> C64WR with CDout=0x3C, CDOE=1, RnW=0; XferEnd once; Busy returns to 0.
- Swap 1 byte, C64=0x11, REU=0x22 -> RAMWRD=0x11, then CDout=0x22; order C64RD, RAMRD, RAMWR, C64WR, STEP, END.
- Verify with C64=0x10, REU=0x11, Length1=0 -> SetVerifyErr pulse, no step strobes, XferEnd next cycle. Repeat with equal data -> STEP, no SetVerifyErr.
- BA=0 for 3 cycles during C64RD and during C64WR -> state held with CAOE (and CDOE) steady; data latched only after BA=1.
- nRESET pulled low during RAMWR while Execute is pulsed -> nDMA=1, RAMReq=0, all strobes 0, Busy=0 immediately; no XferEnd after release; a new Execute starts a clean transfer.
